ex_cdb_arbiter: RTL
===================

Name: ex_cdb_arbiter

Overview:
- Transmitter side of the EX→IC interface. Collects completed results from NUM_FU functional units and buffers them in per-FU FIFOs.
- Round-robin arbiter grants one result per cycle onto the single CDB.
- The granted result is registered into the ex_ic_reg packet consumed by the complete stage.
- Applies backpressure to FUs via per-FU ready and flushes all in-flight results on squash.

Parameters:
- NUM_FU, 4, number of functional-unit result ports.
- FIFO_DEPTH, 2, entries per FU result FIFO (power of 2, ≥2).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset (reset==0 clears state at the rising edge).
- squash  in  1  mispredict flush; drops all buffered and in-flight results.
- fu_valid  in  NUM_FU  per-FU result valid.
- fu_packet  in  NUM_FU x EX_IC_PACKET  per-FU result (rob_idx, dest_tag, result, rs2_value, take_branch; the valid field is ignored).
- fu_ready  out  NUM_FU  per-FU FIFO can accept.
- ex_ic_reg  out  EX_IC_PACKET  registered CDB packet to the complete stage.
- busy  out  1  any FIFO non-empty OR ex_ic_reg.valid.

Behaviour:
- Push to FU i at an edge when fu_valid[i] && fu_ready[i].
- fu_ready[i] = (count[i] < FIFO_DEPTH). This is combinational from count only: no same-cycle pop credit, and no dependence on fu_valid.
- Grant selection (combinational, in the cycle):
  - Scan FIFOs starting at rr_ptr, wrapping modulo NUM_FU.
  - The first non-empty FIFO is granted.
  - At most one grant per cycle.
- At the edge, the granted head is popped and written into ex_ic_reg with valid=1.
- If there is no grant, ex_ic_reg is written all-zero (valid=0, every payload field 0).
- Output is held exactly one cycle per grant; there is no stall input, because the complete stage always accepts.
- rr_ptr update:
  - After a grant to g: rr_ptr = (g+1) mod NUM_FU, so g=NUM_FU-1 wraps to 0.
  - With no grant, rr_ptr holds.
- Latency: a push at edge t appears on ex_ic_reg after edge t+1 at the earliest (2 edges). There is no bypass from fu_packet to output.
- Simultaneous push and pop on the same FIFO: both happen, count unchanged, order preserved. A full FIFO still reports ready=0 that cycle.
- FIFO pointers are log2(FIFO_DEPTH) bits, wrap naturally. count is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
- Squash (priority over everything except reset), at the edge:
  - All FIFO counts and pointers go to 0.
  - Same-cycle pushes are dropped.
  - ex_ic_reg is zeroed.
  - rr_ptr goes to 0.
- Reset (reset==0):
  - Same clearing as squash.
  - Pushes are ignored.
  - Outputs after the edge: ex_ic_reg all-zero, fu_ready all 1, busy 0.
  - Reset mid-operation discards all buffered results.
- Packets leave in per-FU FIFO order. No ordering is guaranteed across FUs beyond round-robin.

Decomposition:
- sys_defs.svh: add `NUM_CDB_FU (4) and `CDB_FIFO_DEPTH (2) defines, used as the parameter defaults.
- Reuse the existing EX_IC_PACKET typedef unchanged.
- Sub-module cdb_fu_fifo: a single-FU FIFO with push/pop/flush, producing head, count and full. It is instantiated NUM_FU times with a generate loop.
- Arbitration and output register stay in ex_cdb_arbiter.

Test Plan:
- Reset: reset=0 for 2 cycles with fu_valid=4'b1111 → ex_ic_reg all-zero, busy=0. After release, fu_ready=4'b1111 and nothing ever emerges.
- Single result:
  - Stimulus: FU2 pushes at edge 0 with rob_idx=5, dest_tag=17, result=32'hDEADBEEF, take_branch=1.
  - Required: after edge 1, ex_ic_reg.valid=1 with those fields; after edge 2, valid=0.
- All-FU burst:
  - Stimulus: all FUs push in one cycle with rob_idx 1,2,3,4.
  - Required: outputs rob_idx 1,2,3,4 on four consecutive cycles; then rr_ptr=0 and busy=0.
- Fairness/backpressure:
  - Stimulus: FU0 asserts fu_valid every cycle; FU3 pushes once.
  - Required: FU3's result emerges within 4 cycles of its push. fu_ready[0] deasserts whenever count[0]=2.
- Squash mid-operation:
  - Stimulus: 3 entries buffered, a new push on FU1 and squash=1 in the same cycle.
  - Required: next cycle ex_ic_reg.valid=0, fu_ready=4'b1111, busy=0; none of the 4 packets ever appears.
- Full FIFO push+pop:
  - Stimulus: FU1 FIFO full, FU1 granted while fu_valid[1]=1.
  - Required: no push that cycle (ready=0), count drops to 1. The next push is accepted and emerges in FIFO order.

Source files
------------

// File: rtl/ex_cdb_arbiter_pkg.sv
// Shared types and defaults for the EX->IC common-data-bus transmitter.
// Holds the result packet layout and the round-robin pointer helper.
package ex_cdb_arbiter_pkg;

   localparam int NUM_CDB_FU     = 4;
   localparam int CDB_FIFO_DEPTH = 2;

   localparam int ROB_IDX_W  = 5;
   localparam int PHYS_TAG_W = 6;
   localparam int XLEN       = 32;

   typedef struct packed {
      logic                  valid;
      logic [ROB_IDX_W-1:0]  rob_idx;
      logic [PHYS_TAG_W-1:0] dest_tag;
      logic [XLEN-1:0]       result;
      logic [XLEN-1:0]       rs2_value;
      logic                  take_branch;
   } EX_IC_PACKET;

   // Next round-robin start point after granting slot g out of n slots.
   function automatic int rrNext(input int g, input int n);
      return (g == n - 1) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/ex_cdb_arbiter_fifo.sv
// Single-FU result FIFO: push/pop/flush with head, occupancy count and full flag.
// Pointers wrap naturally, so DEPTH must be a power of two.
module cdb_fu_fifo
   import ex_cdb_arbiter_pkg::*;
#(
   parameter int DEPTH = CDB_FIFO_DEPTH
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    flush_i,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  EX_IC_PACKET             data_i,
   output EX_IC_PACKET             head_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    full_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   EX_IC_PACKET      mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             doPush, doPop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rdPtr_q];
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && (count_q != '0);

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (doPush) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (doPop) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end
      case ({doPush, doPop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset || flush_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no clearing: occupancy alone decides what is live.
   always_ff @(posedge clock) begin
      if (reset && !flush_i && doPush) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

endmodule

// File: rtl/ex_cdb_arbiter.sv
// EX->IC transmitter: per-FU result FIFOs, round-robin grant onto the single CDB,
// and the registered packet handed to the complete stage.
module ex_cdb_arbiter
   import ex_cdb_arbiter_pkg::*;
#(
   parameter int NUM_FU     = NUM_CDB_FU,
   parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              squash,
   input  logic [NUM_FU-1:0] fu_valid,
   input  EX_IC_PACKET       fu_packet [NUM_FU],
   output logic [NUM_FU-1:0] fu_ready,
   output EX_IC_PACKET       ex_ic_reg,
   output logic              busy
);

   localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   EX_IC_PACKET       fifoHead  [NUM_FU];
   logic [CNT_W-1:0]  fifoCount [NUM_FU];
   logic [NUM_FU-1:0] fifoFull, fifoPush, fifoPop, notEmpty;

   logic [PTR_W-1:0]  rrPtr_q, rrPtr_d;
   logic [PTR_W-1:0]  grantIdx, cand;
   logic              grantValid;
   EX_IC_PACKET       exIc_q, exIc_d;

   for (genvar i = 0; i < NUM_FU; i++) begin : gFifo
      assign fu_ready[i] = !fifoFull[i];
      assign fifoPush[i] = fu_valid[i] && fu_ready[i];
      assign fifoPop[i]  = grantValid && (grantIdx == PTR_W'(i));
      assign notEmpty[i] = (fifoCount[i] != '0);

      cdb_fu_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
         .clock   (clock),
         .reset   (reset),
         .flush_i (squash),
         .push_i  (fifoPush[i]),
         .pop_i   (fifoPop[i]),
         .data_i  (fu_packet[i]),
         .head_o  (fifoHead[i]),
         .count_o (fifoCount[i]),
         .full_o  (fifoFull[i])
      );
   end

   // First non-empty FIFO at or after rrPtr_q, wrapping, wins the bus.
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      cand       = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         cand = PTR_W'((int'(rrPtr_q) + k) % NUM_FU);
         if (!grantValid && notEmpty[cand]) begin
            grantValid = 1'b1;
            grantIdx   = cand;
         end
      end
   end

   always_comb begin
      rrPtr_d = rrPtr_q;
      exIc_d  = '0;
      if (grantValid) begin
         rrPtr_d      = PTR_W'(rrNext(int'(grantIdx), NUM_FU));
         exIc_d       = fifoHead[grantIdx];
         exIc_d.valid = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset || squash) begin
         rrPtr_q <= '0;
         exIc_q  <= '0;
      end else begin
         rrPtr_q <= rrPtr_d;
         exIc_q  <= exIc_d;
      end
   end

   assign ex_ic_reg = exIc_q;
   assign busy      = (|notEmpty) || exIc_q.valid;

endmodule
